adder_ring_counter: RTL and testbench
=====================================

ADDER_RING_COUNTER -- requirements
Module: adder_ring_counter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on ring_in (legal range 2..4).
REQ-002 Parameter COUNT_W, default 32, width of the edge counter and count output.
REQ-003 wb_clk_i  input  1  single clock.
REQ-004 wb_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ring_in  input  1  chain_out of the instrumented adder ring, asynchronous to wb_clk_i.
REQ-006 start  input  1  request a measurement; sampled on the rising edge of wb_clk_i.
REQ-007 window_len  input  16  measurement window in wb_clk_i cycles; captured when start is accepted.
REQ-008 abort  input  1  cancel the measurement in progress.
REQ-009 count  output  COUNT_W  rising edges of ring_in seen during the last window.
REQ-010 busy  output  1  high in ARM and COUNT.
REQ-011 done  output  1  one-cycle pulse when count is final.
REQ-012 overflow  output  1  count saturated; sticky until the next accepted start.

Function
REQ-013 ring_in SHALL pass through a chain of SYNC_STAGES flops, all reset to 0.
- Edge = last sync stage 1 AND previous-value flop 0.
- The previous-value flop SHALL update every cycle.
REQ-014 FSM states SHALL be IDLE, ARM, COUNT and DONE; reset state is IDLE.
REQ-015 IDLE, start=1, abort=0, window_len!=0:
- capture window_len into the timer;
- clear count and overflow;
- go to ARM.
REQ-016 IDLE, start=1, abort=0, window_len==0:
- clear count and overflow;
- go to DONE (count stays 0).
REQ-017 ARM SHALL last exactly one cycle.
- Edges seen in ARM are not counted.
- Next state is COUNT.
REQ-018 COUNT SHALL last exactly window_len cycles.
- Each cycle the timer decrements.
- Each detected edge increments count.
- The cycle the timer reaches 0, go to DONE.
REQ-019 Count arithmetic SHALL saturate at all-ones.
- An edge while count is all-ones sets overflow.
- count does not wrap.
REQ-020 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-021 Latency: start accepted at edge k gives ARM at k+1, COUNT at k+2..k+window_len+1, done high at k+window_len+2.
REQ-022 count and overflow SHALL hold their values from DONE until the next accepted start.
REQ-023 start SHALL be ignored while in ARM, COUNT or DONE.
REQ-024 abort in ARM or COUNT SHALL return to IDLE on the next edge.
- No done pulse.
- count holds the partial value.
REQ-025 abort in IDLE or DONE SHALL have no effect; abort with start in IDLE means start is ignored.
REQ-026 Edges on ring_in faster than wb_clk_i/2 are out of spec; the counter SHALL count at most one edge per cycle.

Reset
REQ-027 When wb_rst_n is low, the block SHALL immediately (asynchronously) force:
- FSM to IDLE;
- count=0, busy=0, done=0, overflow=0;
- timer=0 and all synchroniser flops to 0.
REQ-028 Reset asserted mid-window SHALL discard the measurement; no done pulse follows deassertion.
REQ-029 After deassertion, the first start SHALL be accepted on the first rising edge of wb_clk_i.

Verification
REQ-030 Bench SHALL cover:
- Reset: assert wb_rst_n=0 mid-COUNT, between clock edges -> count=0, busy=0, done=0, overflow=0 without a clock edge; no done after release.
- Nominal: ring_in period 8 clocks (4 high/4 low), running from before start; start with window_len=80 -> busy high 81 cycles; done at start+82; count=10; overflow=0.
- Zero window: start with window_len=0 -> done high exactly 2 cycles after start; count=0; busy never high.
- Saturation: COUNT_W=4, ring_in period 4 clocks, window_len=100 -> count=15, overflow=1 at done; next start clears overflow to 0.
- Abort/ignore: start, window_len=50, abort at cycle 20 of COUNT -> busy low next cycle; no done; count holds partial value. A second start during COUNT of another run -> ignored; window length unchanged.

Source files
------------

// File: rtl/adder_ring_counter.sv
// adder_ring_counter: counts synchronised rising edges of an adder-ring output over a timed window
// Ports:
//   wb_clk_i   - clock
//   wb_rst_n   - asynchronous active-low reset
//   ring_in    - ring chain output, asynchronous to wb_clk_i
//   start      - request a measurement (accepted only in IDLE without abort)
//   window_len - window length in clock cycles, captured at start
//   abort      - cancel a measurement in ARM or COUNT
//   count      - saturating edge count of the last window
//   busy       - high in ARM and COUNT
//   done       - one-cycle pulse when count is final
//   overflow   - sticky saturation flag, cleared by the next accepted start
module adder_ring_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 32
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    input  logic               ring_in,
    input  logic               start,
    input  logic [15:0]        window_len,
    input  logic               abort,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               done,
    output logic               overflow
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;
    state_t                   r_state;
    state_t                   w_next;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_prev;
    logic [15:0]              r_timer;
    logic [COUNT_W-1:0]       r_count;
    logic                     r_ovf;
    logic                     w_edge;
    logic                     w_accept;
    assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign count    = r_count;
    assign overflow = r_ovf;
    assign busy     = (r_state == S_ARM) || (r_state == S_COUNT);
    // A zero-length window parks in DONE one extra cycle (timer preloaded to 1) so
    // done lands at the same start+window+2 point as every other window.
    assign done     = (r_state == S_DONE) && (r_timer == 16'd0);
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ring_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (window_len == 16'd0) ? S_DONE : S_ARM;
            S_ARM:   w_next = abort ? S_IDLE : S_COUNT;
            S_COUNT: w_next = abort ? S_IDLE : ((r_timer == 16'd1) ? S_DONE : S_COUNT);
            S_DONE:  w_next = (r_timer == 16'd0) ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end
    // Abort wins over counting: the edge sampled on the abort cycle is not counted.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_timer <= (window_len == 16'd0) ? 16'd1 : window_len;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (r_state == S_COUNT && !abort) begin
                r_timer <= r_timer - 16'd1;
                if (w_edge) begin
                    if (&r_count) r_ovf <= 1'b1;
                    else r_count <= r_count + 1'b1;
                end
            end else if (r_state == S_DONE && r_timer != 16'd0) begin
                r_timer <= r_timer - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_adder_ring_counter.sv
// tb_adder_ring_counter: randomized self-checking bench for adder_ring_counter
module tb_adder_ring_counter;
    logic        clk, wb_rst_n, ring_in, start, abort;
    logic [15:0] window_len;
    logic [31:0] a_count;
    logic [3:0]  b_count;
    logic        a_busy, a_done, a_ovf, b_busy, b_done, b_ovf;
    int          checks = 0, failures = 0;
    int          n = 0, base = 0, ring_p = 8, ph = 0;
    bit          ring_rand = 0;
    bit          hist [0:9999];

    adder_ring_counter dut_a (
        .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .ring_in(ring_in), .start(start),
        .window_len(window_len), .abort(abort), .count(a_count), .busy(a_busy),
        .done(a_done), .overflow(a_ovf)
    );
    adder_ring_counter #(.SYNC_STAGES(3), .COUNT_W(4)) dut_b (
        .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .ring_in(ring_in), .start(start),
        .window_len(window_len), .abort(abort), .count(b_count), .busy(b_busy),
        .done(b_done), .overflow(b_ovf)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (n < 10000) hist[n] = ring_in;
        n = n + 1;
    end

    initial begin
        ring_in = 0;
        forever begin
            @(negedge clk);
            ph++;
            ring_in = ring_rand ? 1'($urandom_range(0, 1)) : ((ph % ring_p) < ring_p / 2);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit h(input int i);
        return (i < base || i < 0 || i >= 10000) ? 1'b0 : hist[i];
    endfunction

    // Rising edges of the ring as seen through an s-stage synchroniser, counted on edges from..to.
    function automatic int model_edges(input int s, input int from, input int to);
        int c = 0;
        for (int m = from; m <= to; m++) c += (h(m - s) && !h(m - s - 1)) ? 1 : 0;
        return c;
    endfunction

    // Called at a negedge with the DUT idle; start is accepted on the next rising edge.
    task automatic measure(input string tag, input int w, input int abort_j, input int restart_j);
        int k, busy_n, done_n, done_j, last, ea, eb, exp_busy;
        busy_n = 0; done_n = 0; done_j = -1;
        start = 1; abort = 0; window_len = 16'(w);
        @(negedge clk);
        k = n - 1;
        start = 0;
        for (int j = 0; j <= w + 4; j++) begin
            if (j > 0) @(negedge clk);
            busy_n += int'(a_busy) + int'(b_busy);
            done_n += int'(a_done) + int'(b_done);
            if (a_done) done_j = j;
            abort = (j == abort_j);
            start = (j == restart_j);
            if (start) window_len = 16'(w + 9);
        end
        abort = 0; start = 0;
        last = (abort_j >= 0) ? k + abort_j : k + w + 1;
        ea = model_edges(2, k + 2, last);
        eb = model_edges(3, k + 2, last);
        exp_busy = (abort_j >= 0) ? abort_j + 1 : ((w > 0) ? w + 1 : 0);
        chk({tag, "_cnt_a"}, 64'(a_count), 64'(ea));
        chk({tag, "_cnt_b"}, 64'(b_count), 64'((eb > 15) ? 15 : eb));
        chk({tag, "_ovf_a"}, 64'(a_ovf), 64'd0);
        chk({tag, "_ovf_b"}, 64'(b_ovf), 64'(eb > 15));
        chk({tag, "_busy_n"}, 64'(busy_n), 64'(2 * exp_busy));
        chk({tag, "_done_n"}, 64'(done_n), 64'((abort_j >= 0) ? 0 : 2));
        if (abort_j < 0) chk({tag, "_done_j"}, 64'(done_j), 64'(w + 1));
    endtask

    initial begin
        int busy_n, done_n;
        wb_rst_n = 0; start = 0; abort = 0; window_len = 0;
        #1;
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_outs", 64'({a_busy, a_done, a_ovf, b_busy, b_done, b_ovf}), 64'd0);
        @(negedge clk); @(negedge clk);
        wb_rst_n = 1; base = n;
        repeat (12) @(negedge clk);
        measure("nominal", 80, -1, -1);
        chk("nominal_cnt10", 64'(a_count), 64'd10);
        measure("zero", 0, -1, -1);
        ring_p = 4;
        repeat (4) @(negedge clk);
        measure("sat", 100, -1, -1);
        chk("sat_cnt15", 64'(b_count), 64'd15);
        chk("sat_ovf1", 64'(b_ovf), 64'd1);
        measure("sat_clear", 3, -1, -1);
        ring_p = 6;
        measure("abort", 50, 20, -1);
        measure("restart", 40, -1, 15);
        measure("abort_arm", 10, 0, -1);
        start = 1; abort = 1; window_len = 16'd10;
        @(negedge clk);
        start = 0; abort = 0;
        chk("start_abort_busy", 64'({a_busy, b_busy}), 64'd0);
        @(negedge clk);
        chk("start_abort_done", 64'({a_done, b_done, a_busy}), 64'd0);
        ring_p = 8;
        start = 1; window_len = 16'd80;
        @(negedge clk);
        start = 0;
        repeat (30) @(negedge clk);
        @(posedge clk);
        #3 wb_rst_n = 0;
        #1;
        chk("async_rst_cnt", 64'(a_count), 64'd0);
        chk("async_rst_outs", 64'({a_busy, a_done, a_ovf, b_busy, b_done, b_ovf, b_count}), 64'd0);
        @(negedge clk); @(negedge clk);
        wb_rst_n = 1; base = n;
        busy_n = 0; done_n = 0;
        repeat (100) begin
            @(negedge clk);
            busy_n += int'(a_busy);
            done_n += int'(a_done) + int'(b_done);
        end
        chk("post_rst_no_done", 64'(done_n), 64'd0);
        chk("post_rst_no_busy", 64'(busy_n), 64'd0);
        wb_rst_n = 0;
        @(negedge clk);
        wb_rst_n = 1; base = n;
        measure("first_start", 5, -1, -1);
        for (int t = 0; t < 12; t++) begin
            int w, ab, rs;
            ring_rand = 1'($urandom_range(0, 1));
            ring_p = $urandom_range(2, 10);
            w = $urandom_range(0, 40);
            ab = (w > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, w) : -1;
            rs = (ab < 0 && w > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, w - 1) : -1;
            measure("rand", w, ab, rs);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
